// File: rtl/fpu_norm_pkg.sv
// Shared types and constants for the sequential FP normaliser:
// FSM state encoding, guard/round/sticky bit positions and an exponent
// all-ones helper.
package fpu_norm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bit positions inside the 3-bit {guard, round, sticky} vector
    localparam int GRS_G = 2;
    localparam int GRS_R = 1;
    localparam int GRS_S = 0;

    // All-ones value of a w-bit exponent field (Inf/NaN / overflow code)
    function automatic logic [31:0] exp_max(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero counter over a small window. Returns W when the window is
// all zeros. Used to size each left-shift step of the normaliser.
module fpu_lzc #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_bits,
    output logic [CW-1:0] o_count
);

    // Scan LSB to MSB so the highest set bit determines the count
    always_comb begin
        o_count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_bits[i]) begin
                o_count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpu_normalizer_seq.sv
// Multi-cycle floating-point result normaliser.
// Takes an unrounded mantissa {carry, hidden, fraction} with guard/round/
// sticky bits, normalises it by at most SHIFT_STEP bits per cycle, rounds
// and reports overflow / underflow / inexact.
// Optional feature macro FPU_NORM_ROUND_EN: when defined, round to nearest
// even; when undefined, truncate (inexact is reported either way).
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE (and never while reset is
// asserted); out_valid is high only in DONE and outputs stay stable until
// out_ready is seen; the block returns to IDLE on that edge, so a new
// operand cannot be accepted in the same cycle a result is taken.
module fpu_normalizer_seq
    import fpu_norm_pkg::*;
#(
    parameter int MANT_W     = 23,
    parameter int EXP_W      = 8,
    parameter int SHIFT_STEP = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic              i_in_sign,
    input  logic [EXP_W-1:0]  i_in_exp,
    input  logic [MANT_W+1:0] i_in_mant,
    input  logic [2:0]        i_in_grs,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_sign,
    output logic [EXP_W-1:0]  o_out_exp,
    output logic [MANT_W-1:0] o_out_mant,
    output logic              o_out_overflow,
    output logic              o_out_underflow,
    output logic              o_out_inexact,
    output logic [1:0]        o_dbg_state
);

    localparam int MW2 = MANT_W + 2;              // carry, hidden, fraction
    localparam int FW  = MANT_W + 4;              // mantissa plus G and R
    localparam int CW  = $clog2(SHIFT_STEP + 1);
    localparam logic [EXP_W:0] LP_EXP_MAX = (EXP_W + 1)'(exp_max(EXP_W));

    state_t              r_state;
    state_t              w_next_state;

    // Working operand; exponent carries one extra bit so +1 never wraps
    logic                r_sign;
    logic [EXP_W:0]      r_exp;
    logic [MW2-1:0]      r_mant;
    logic [2:0]          r_grs;

    logic                r_out_sign;
    logic [EXP_W-1:0]    r_out_exp;
    logic [MANT_W-1:0]   r_out_mant;
    logic                r_out_overflow;
    logic                r_out_underflow;
    logic                r_out_inexact;

    logic                w_accept;
    logic                w_in_special;
    logic                w_in_zero;
    logic                w_in_carry;
    logic                w_in_norm;

    logic [MW2-1:0]      w_shift_src;
    logic [SHIFT_STEP-1:0] w_window;
    logic [CW-1:0]       w_lz;
    logic [EXP_W:0]      w_k;
    logic [FW-1:0]       w_full;
    logic [EXP_W:0]      w_sh_exp;
    logic                w_shift_exit;

    logic                w_inc;
    logic [MW2-1:0]      w_sum;
    logic [MW2-1:0]      w_rnd_mant;
    logic [EXP_W:0]      w_rnd_exp;
    logic                w_rnd_ovf;
    logic                w_rnd_unf;
    logic                w_rnd_inx;

    assign w_accept     = i_in_valid && o_in_ready;
    assign w_in_special = &i_in_exp;
    assign w_in_zero    = (i_in_mant == '0) && (i_in_grs == '0);
    assign w_in_carry   = i_in_mant[MANT_W+1];
    assign w_in_norm    = i_in_mant[MANT_W] || (i_in_exp == '0);

    // Window just below the hidden bit; G and R take part so they can be
    // pulled up into the fraction
    assign w_shift_src = {r_mant[MANT_W-1:0], r_grs[GRS_G], r_grs[GRS_R]};
    assign w_window    = w_shift_src[MW2-1 -: SHIFT_STEP];

    fpu_lzc #(
        .W  (SHIFT_STEP),
        .CW (CW)
    ) u_lzc (
        .i_bits  (w_window),
        .o_count (w_lz)
    );

    // Shift distance this cycle: reach the hidden bit, but never more than
    // one step and never below exponent zero
    always_comb begin
        w_k = (EXP_W + 1)'(w_lz) + (EXP_W + 1)'(1);
        if (w_k > (EXP_W + 1)'(SHIFT_STEP)) begin
            w_k = (EXP_W + 1)'(SHIFT_STEP);
        end
        if (w_k > r_exp) begin
            w_k = r_exp;
        end
        w_full       = {r_mant, r_grs[GRS_G], r_grs[GRS_R]} << w_k;
        w_sh_exp     = r_exp - w_k;
        w_shift_exit = w_full[MANT_W+2] || (w_sh_exp == '0);
    end

    // Rounding, post-round renormalisation and exception flags
    always_comb begin
        w_inc = 1'b0;
`ifdef FPU_NORM_ROUND_EN
        w_inc = r_grs[GRS_G] & (r_grs[GRS_R] | r_grs[GRS_S] | r_mant[0]);
`endif
        w_sum      = r_mant + MW2'(w_inc);
        w_rnd_mant = w_sum;
        w_rnd_exp  = r_exp;
        w_rnd_ovf  = 1'b0;
        w_rnd_unf  = 1'b0;
        w_rnd_inx  = |r_grs;
        if (w_sum[MANT_W+1]) begin
            w_rnd_mant = w_sum >> 1;
            w_rnd_exp  = r_exp + (EXP_W + 1)'(1);
        end else if ((r_exp == '0) && w_sum[MANT_W]) begin
            // Denormal rounded up into the smallest normal
            w_rnd_exp = (EXP_W + 1)'(1);
        end
        if (w_rnd_exp >= LP_EXP_MAX) begin
            w_rnd_ovf  = 1'b1;
            w_rnd_exp  = LP_EXP_MAX;
            w_rnd_mant = '0;
        end else if (w_rnd_exp == '0) begin
            w_rnd_unf = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_in_special || w_in_zero) begin
                        w_next_state = ST_DONE;
                    end else if (w_in_carry || w_in_norm) begin
                        w_next_state = ST_ROUND;
                    end else begin
                        w_next_state = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (w_shift_exit) begin
                    w_next_state = ST_ROUND;
                end
            end
            ST_ROUND: w_next_state = ST_DONE;
            ST_DONE: begin
                if (i_out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake flags and debug state
    always_comb begin
        o_in_ready  = (r_state == ST_IDLE) && i_rst_n;
        o_out_valid = (r_state == ST_DONE);
        o_dbg_state = r_state;
    end

    // Datapath: capture, per-cycle shift and result registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sign          <= 1'b0;
            r_exp           <= '0;
            r_mant          <= '0;
            r_grs           <= '0;
            r_out_sign      <= 1'b0;
            r_out_exp       <= '0;
            r_out_mant      <= '0;
            r_out_overflow  <= 1'b0;
            r_out_underflow <= 1'b0;
            r_out_inexact   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sign <= i_in_sign;
                        if (w_in_special) begin
                            r_out_sign      <= i_in_sign;
                            r_out_exp       <= i_in_exp;
                            r_out_mant      <= i_in_mant[MANT_W-1:0];
                            r_out_overflow  <= 1'b0;
                            r_out_underflow <= 1'b0;
                            r_out_inexact   <= 1'b0;
                        end else if (w_in_zero) begin
                            r_out_sign      <= i_in_sign;
                            r_out_exp       <= '0;
                            r_out_mant      <= '0;
                            r_out_overflow  <= 1'b0;
                            r_out_underflow <= 1'b1;
                            r_out_inexact   <= 1'b0;
                        end else if (w_in_carry) begin
                            r_mant <= i_in_mant >> 1;
                            r_grs  <= {i_in_mant[0], i_in_grs[GRS_G],
                                       i_in_grs[GRS_R] | i_in_grs[GRS_S]};
                            r_exp  <= {1'b0, i_in_exp} + (EXP_W + 1)'(1);
                        end else begin
                            r_mant <= i_in_mant;
                            r_grs  <= i_in_grs;
                            r_exp  <= {1'b0, i_in_exp};
                        end
                    end
                end
                ST_SHIFT: begin
                    r_mant <= w_full[FW-1:2];
                    r_grs  <= {w_full[1], w_full[0], r_grs[GRS_S]};
                    r_exp  <= w_sh_exp;
                end
                ST_ROUND: begin
                    r_out_sign      <= r_sign;
                    r_out_exp       <= w_rnd_exp[EXP_W-1:0];
                    r_out_mant      <= w_rnd_mant[MANT_W-1:0];
                    r_out_overflow  <= w_rnd_ovf;
                    r_out_underflow <= w_rnd_unf;
                    r_out_inexact   <= w_rnd_inx;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_out_sign      = r_out_sign;
    assign o_out_exp       = r_out_exp;
    assign o_out_mant      = r_out_mant;
    assign o_out_overflow  = r_out_overflow;
    assign o_out_underflow = r_out_underflow;
    assign o_out_inexact   = r_out_inexact;

endmodule

// File: tb/tb_fpu_normalizer_seq.sv
// Bench for fpu_normalizer_seq (MANT_W=23, EXP_W=8, SHIFT_STEP=4).
// Expected results follow FPU_NORM_ROUND_EN when it is defined.
module tb_fpu_normalizer_seq;

    localparam int MANT_W     = 23;
    localparam int EXP_W      = 8;
    localparam int SHIFT_STEP = 4;
    localparam int RW         = 1 + EXP_W + MANT_W + 3;
    localparam int NV         = 14;

    typedef struct {
        logic          sign;
        logic [7:0]    exp;
        logic [24:0]   mant;
        logic [2:0]    grs;
        logic [RW-1:0] expv;
        int            lat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic [7:0]    in_exp;
    logic [24:0]   in_mant;
    logic [2:0]    in_grs;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic [7:0]    out_exp;
    logic [22:0]   out_mant;
    logic          out_overflow;
    logic          out_underflow;
    logic          out_inexact;
    logic [1:0]    dbg_state;
    logic [RW-1:0] res;

    logic [RW-1:0] exp_q[$];
    vec_t          vecs[NV];
    int            checks   = 0;
    int            failures = 0;

    fpu_normalizer_seq #(
        .MANT_W     (MANT_W),
        .EXP_W      (EXP_W),
        .SHIFT_STEP (SHIFT_STEP)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_in_valid      (in_valid),
        .o_in_ready      (in_ready),
        .i_in_sign       (in_sign),
        .i_in_exp        (in_exp),
        .i_in_mant       (in_mant),
        .i_in_grs        (in_grs),
        .o_out_valid     (out_valid),
        .i_out_ready     (out_ready),
        .o_out_sign      (out_sign),
        .o_out_exp       (out_exp),
        .o_out_mant      (out_mant),
        .o_out_overflow  (out_overflow),
        .o_out_underflow (out_underflow),
        .o_out_inexact   (out_inexact),
        .o_dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    assign res = {out_sign, out_exp, out_mant, out_overflow, out_underflow, out_inexact};

    function automatic logic [RW-1:0] pk(input logic s, input logic [7:0] e,
                                         input logic [22:0] m, input logic o,
                                         input logic u, input logic i);
        return {s, e, m, o, u, i};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, want);
        end
    endtask

    task automatic set_vec(input int idx, input logic s, input logic [7:0] e,
                           input logic [24:0] m, input logic [2:0] g,
                           input logic [RW-1:0] ev, input int lat);
        vecs[idx].sign = s;
        vecs[idx].exp  = e;
        vecs[idx].mant = m;
        vecs[idx].grs  = g;
        vecs[idx].expv = ev;
        vecs[idx].lat  = lat;
    endtask

    // Drive one operand, wait for its result, optionally hold off out_ready
    task automatic run_vec(input int id, input vec_t v, input int hold);
        int            lat;
        bit            got;
        logic [RW-1:0] want;
        out_ready = (hold == 0);
        chk($sformatf("v%0d_in_ready_idle", id), 64'(in_ready), 64'(1));
        in_sign  = v.sign;
        in_exp   = v.exp;
        in_mant  = v.mant;
        in_grs   = v.grs;
        in_valid = 1'b1;
        exp_q.push_back(v.expv);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d_out_valid_seen", id), 64'(got), 64'(1));
        if (got) begin
            chk($sformatf("v%0d_latency", id), 64'(lat), 64'(v.lat));
            chk($sformatf("v%0d_in_ready_busy", id), 64'(in_ready), 64'(0));
            want = exp_q.pop_front();
            chk($sformatf("v%0d_result", id), 64'(res), 64'(want));
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                chk($sformatf("v%0d_hold%0d", id, h),
                    64'({out_valid, in_ready, res}), 64'({1'b1, 1'b0, want}));
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid_cleared", id), 64'(out_valid), 64'(0));
            chk($sformatf("v%0d_in_ready_back", id), 64'(in_ready), 64'(1));
        end else begin
            exp_q.delete();
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
        end
    endtask

    initial begin
        vec_t rv;
        bit   seen;
        logic [22:0] frac;

        // Vector table: {sign, exp, mant, grs} -> packed result, latency
        set_vec(0,  0, 8'h80, 25'h1800000, 3'b000, pk(0, 8'h81, 23'h400000, 0, 0, 0), 2);
        set_vec(1,  0, 8'h80, 25'h0000001, 3'b000, pk(0, 8'h69, 23'h000000, 0, 0, 0), 8);
        set_vec(2,  0, 8'h03, 25'h0000100, 3'b000, pk(0, 8'h00, 23'h000800, 0, 1, 0), 3);
        set_vec(4,  0, 8'hFE, 25'h1800000, 3'b000, pk(0, 8'hFF, 23'h000000, 1, 0, 0), 2);
        set_vec(5,  1, 8'hFF, 25'h0123456, 3'b111, pk(1, 8'hFF, 23'h123456, 0, 0, 0), 1);
        set_vec(6,  1, 8'h55, 25'h0000000, 3'b000, pk(1, 8'h00, 23'h000000, 0, 1, 0), 1);
        set_vec(8,  0, 8'h00, 25'h0000ABC, 3'b000, pk(0, 8'h00, 23'h000ABC, 0, 1, 0), 2);
        set_vec(9,  0, 8'h40, 25'h0000000, 3'b100, pk(0, 8'h28, 23'h000000, 0, 0, 0), 8);
        set_vec(10, 0, 8'h02, 25'h0000003, 3'b001, pk(0, 8'h00, 23'h00000C, 0, 1, 1), 3);
        set_vec(11, 0, 8'h80, 25'h0200000, 3'b000, pk(0, 8'h7E, 23'h000000, 0, 0, 0), 3);
`ifdef FPU_NORM_ROUND_EN
        set_vec(3,  0, 8'h7F, 25'h0FFFFFF, 3'b100, pk(0, 8'h80, 23'h000000, 0, 0, 1), 2);
        set_vec(7,  0, 8'h10, 25'h1000001, 3'b011, pk(0, 8'h11, 23'h000001, 0, 0, 1), 2);
        set_vec(12, 0, 8'h00, 25'h07FFFFF, 3'b110, pk(0, 8'h01, 23'h000000, 0, 0, 1), 2);
        set_vec(13, 0, 8'hFE, 25'h0FFFFFF, 3'b110, pk(0, 8'hFF, 23'h000000, 1, 0, 1), 2);
`else
        set_vec(3,  0, 8'h7F, 25'h0FFFFFF, 3'b100, pk(0, 8'h7F, 23'h7FFFFF, 0, 0, 1), 2);
        set_vec(7,  0, 8'h10, 25'h1000001, 3'b011, pk(0, 8'h11, 23'h000000, 0, 0, 1), 2);
        set_vec(12, 0, 8'h00, 25'h07FFFFF, 3'b110, pk(0, 8'h00, 23'h7FFFFF, 0, 1, 1), 2);
        set_vec(13, 0, 8'hFE, 25'h0FFFFFF, 3'b110, pk(0, 8'hFE, 23'h7FFFFF, 0, 0, 1), 2);
`endif

        // Clock/reset
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        in_grs    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(0));
        chk("reset_outputs", 64'(res), 64'(0));
        chk("reset_state", 64'(dbg_state), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", 64'(in_ready), 64'(1));

        // Table-driven pass
        for (int i = 0; i < NV; i++) begin
            run_vec(i, vecs[i], 0);
        end

        // Back-pressure: result held for 5 cycles with out_ready low
        run_vec(100, vecs[0], 5);

        // Reset in the middle of a long shift sequence discards the operation
        in_sign  = vecs[1].sign;
        in_exp   = vecs[1].exp;
        in_mant  = vecs[1].mant;
        in_grs   = vecs[1].grs;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_shift_state", 64'(dbg_state), 64'(1));
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
        chk("rst_mid_in_ready", 64'(in_ready), 64'(0));
        chk("rst_mid_state", 64'(dbg_state), 64'(0));
        chk("rst_mid_outputs", 64'(res), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_release_ready", 64'(in_ready), 64'(1));
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("rst_mid_no_output", 64'(seen), 64'(0));

        // Random already-normalised operands with random consumer stalls
        for (int i = 0; i < 8; i++) begin
            frac    = 23'($urandom_range(0, 32'h7FFFFF));
            rv.sign = 1'($urandom_range(0, 1));
            rv.exp  = 8'($urandom_range(1, 254));
            rv.mant = {2'b01, frac};
            rv.grs  = 3'b000;
            rv.expv = pk(rv.sign, rv.exp, frac, 0, 0, 0);
            rv.lat  = 2;
            run_vec(200 + i, rv, $urandom_range(0, 3));
        end

        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
